led_pattern_ctrl: RTL and testbench



---
 rtl/led_pattern_ctrl.sv | 168 ++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - debounced switch-driven LED pattern engine (steady, blink, chase, ping-pong)
module led_pattern_ctrl #(
  parameter int N_LED      = 16,
  parameter int CLK_HZ     = 100_000_000,
  parameter int STEP_HZ    = 4,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SW_EN,
  input  logic [1:0]       SW_MODE,
  output logic [N_LED-1:0] LED,
  output logic             TICK
);

  localparam int TICK_DIV = CLK_HZ / STEP_HZ;
  localparam int TW       = $clog2(TICK_DIV);
  localparam int DW       = $clog2(DEB_CYCLES + 1);

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  logic             r_en_s1;
  logic             r_en_s2;
  logic [1:0]       r_mode_s1;
  logic [1:0]       r_mode_s2;
  logic             r_en_db;
  logic [1:0]       r_mode_db;
  logic [DW-1:0]    r_en_cnt;
  logic [DW-1:0]    r_mode_cnt;
  logic             r_en_db_d;
  logic [1:0]       r_mode_db_d;
  logic [TW-1:0]    r_tick_cnt;
  logic [N_LED-1:0] r_pat;
  dir_t             r_dir;

  logic             w_restart;
  logic             w_tick;
  logic [N_LED-1:0] w_init;

  // Restart on enable rising, or on a mode change while already enabled
  assign w_restart = r_en_db & (~r_en_db_d | (r_mode_db != r_mode_db_d));
  // A tick that coincides with a restart is dropped
  assign w_tick    = r_en_db & ~w_restart & (r_tick_cnt == TICK_MAX);
  // Steady/blink start fully lit; chase/ping-pong start with bit0 only
  assign w_init    = r_mode_db[1] ? N_LED'(1) : {N_LED{1'b1}};

  // Two-flop synchronisers for the raw switch inputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_en_s1   <= 1'b0;
      r_en_s2   <= 1'b0;
      r_mode_s1 <= 2'b00;
      r_mode_s2 <= 2'b00;
    end else begin
      r_en_s1   <= SW_EN;
      r_en_s2   <= r_en_s1;
      r_mode_s1 <= SW_MODE;
      r_mode_s2 <= r_mode_s1;
    end
  end

  // Enable debounce: s1 != s2 means the synced value changes on this edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_en_db  <= 1'b0;
      r_en_cnt <= '0;
    end else if ((r_en_s1 != r_en_s2) || (r_en_s2 == r_en_db)) begin
      r_en_cnt <= '0;
    end else if (r_en_cnt == DEB_MAX) begin
      r_en_db  <= r_en_s2;
      r_en_cnt <= '0;
    end else begin
      r_en_cnt <= r_en_cnt + DW'(1);
    end
  end

  // Mode debounce: both mode bits are qualified together as one group
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode_db  <= 2'b00;
      r_mode_cnt <= '0;
    end else if ((r_mode_s1 != r_mode_s2) || (r_mode_s2 == r_mode_db)) begin
      r_mode_cnt <= '0;
    end else if (r_mode_cnt == DEB_MAX) begin
      r_mode_db  <= r_mode_s2;
      r_mode_cnt <= '0;
    end else begin
      r_mode_cnt <= r_mode_cnt + DW'(1);
    end
  end

  // Delayed debounced values for restart edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_en_db_d   <= 1'b0;
      r_mode_db_d <= 2'b00;
    end else begin
      r_en_db_d   <= r_en_db;
      r_mode_db_d <= r_mode_db;
    end
  end

  // Step divider: idles at zero while disabled, cleared on restart
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tick_cnt <= '0;
      TICK       <= 1'b0;
    end else begin
      TICK <= w_tick;
      if (!r_en_db || w_restart || (r_tick_cnt == TICK_MAX)) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + TW'(1);
      end
    end
  end

  // Pattern register; cleared while disabled so stale patterns never reach the LEDs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pat <= '0;
      r_dir <= DIR_LEFT;
    end else if (w_restart) begin
      r_pat <= w_init;
      r_dir <= DIR_LEFT;
    end else if (!r_en_db) begin
      r_pat <= '0;
      r_dir <= DIR_LEFT;
    end else if (w_tick) begin
      case (r_mode_db)
        2'b00: r_pat <= r_pat;
        2'b01: r_pat <= ~r_pat;
        2'b10: r_pat <= (r_pat << 1) | (r_pat >> (N_LED - 1));
        default: begin
          if (N_LED == 1) begin
            r_pat <= r_pat;
          end else if (r_pat[N_LED-1]) begin
            r_pat <= r_pat >> 1;
            r_dir <= DIR_RIGHT;
          end else if (r_pat[0]) begin
            r_pat <= r_pat << 1;
            r_dir <= DIR_LEFT;
          end else if (r_dir == DIR_LEFT) begin
            r_pat <= r_pat << 1;
          end else begin
            r_pat <= r_pat >> 1;
          end
        end
      endcase
    end
  end

  // LED drive follows the pattern one cycle later, blanked when disabled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LED <= '0;
    end else begin
      LED <= r_en_db ? r_pat : '0;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - table-driven bench for led_pattern_ctrl
module tb_led_pattern_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SW_EN = 1'b0;
  logic [1:0] SW_MODE = 2'b00;
  logic [7:0] LED;
  logic       TICK;

  int n_total = 0;
  int n_bad   = 0;
  int ecount  = 0;

  typedef struct {
    int         cyc;
    logic [7:0] led;
    logic       tick;
    logic       en;
    logic [1:0] mode;
  } vec_t;

  vec_t tbl[$];

  led_pattern_ctrl #(
    .N_LED(8),
    .CLK_HZ(100),
    .STEP_HZ(10),
    .DEB_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .SW_EN(SW_EN),
    .SW_MODE(SW_MODE),
    .LED(LED),
    .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    @(negedge CLK);
    ecount++;
  endtask

  task automatic run_to(input int target);
    while (ecount < target) adv();
  endtask

  task automatic add(input int c, input logic [7:0] l, input logic t,
                     input logic e, input logic [1:0] m);
    vec_t v;
    v.cyc = c; v.led = l; v.tick = t; v.en = e; v.mode = m;
    tbl.push_back(v);
  endtask

  initial begin
    // cycle, expected LED, expected TICK, then switches applied after the check
    add(  0, 8'h00, 0, 1, 2'b10);
    add(  7, 8'h00, 0, 1, 2'b10);
    add(  8, 8'h01, 0, 1, 2'b10);
    add( 16, 8'h01, 0, 1, 2'b10);
    add( 17, 8'h01, 1, 1, 2'b10);
    add( 18, 8'h02, 0, 1, 2'b10);
    add( 28, 8'h04, 0, 1, 2'b10);
    add( 78, 8'h80, 0, 1, 2'b10);
    add( 87, 8'h80, 1, 1, 2'b10);
    add( 88, 8'h01, 0, 1, 2'b10);
    add(118, 8'h08, 0, 1, 2'b10);
    add(120, 8'h08, 0, 1, 2'b00);
    add(127, 8'h08, 0, 1, 2'b00);
    add(128, 8'hFF, 0, 1, 2'b00);
    add(137, 8'hFF, 1, 1, 2'b00);
    add(150, 8'hFF, 0, 0, 2'b00);
    add(156, 8'hFF, 0, 0, 2'b00);
    add(157, 8'h00, 0, 0, 2'b00);
    add(160, 8'h00, 0, 1, 2'b01);
    add(167, 8'h00, 0, 1, 2'b01);
    add(168, 8'hFF, 0, 1, 2'b01);
    add(177, 8'hFF, 1, 1, 2'b01);
    add(178, 8'h00, 0, 1, 2'b01);
    add(187, 8'h00, 1, 1, 2'b01);
    add(188, 8'hFF, 0, 1, 2'b01);
    add(190, 8'hFF, 0, 1, 2'b11);
    add(197, 8'hFF, 0, 1, 2'b11);
    add(198, 8'h01, 0, 1, 2'b11);
    add(208, 8'h02, 0, 1, 2'b11);
    add(268, 8'h80, 0, 1, 2'b11);
    add(277, 8'h80, 1, 1, 2'b11);
    add(278, 8'h40, 0, 1, 2'b11);
    add(338, 8'h01, 0, 1, 2'b11);
    add(347, 8'h01, 1, 1, 2'b11);
    add(348, 8'h02, 0, 1, 2'b11);
    add(350, 8'h02, 0, 0, 2'b11);
    add(357, 8'h00, 0, 0, 2'b11);
    add(360, 8'h00, 0, 0, 2'b00);
    add(370, 8'h00, 0, 1, 2'b00);
    add(373, 8'h00, 0, 0, 2'b00);
    add(390, 8'h00, 0, 0, 2'b00);
    add(400, 8'h00, 0, 1, 2'b00);
    add(406, 8'h00, 0, 0, 2'b00);
    add(407, 8'h00, 0, 0, 2'b00);
    add(408, 8'hFF, 0, 0, 2'b00);
    add(412, 8'hFF, 0, 0, 2'b00);
    add(413, 8'h00, 0, 0, 2'b00);
    add(420, 8'h00, 0, 1, 2'b11);

    SW_EN   = 1'b1;
    SW_MODE = 2'b10;
    #1 RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("reset_led", LED, 8'h00);
      chk("reset_tick", {7'b0, TICK}, 8'h00);
    end
    RST = 1'b0;
    ecount = 0;

    foreach (tbl[i]) begin
      run_to(tbl[i].cyc);
      chk($sformatf("led@%0d", tbl[i].cyc), LED, tbl[i].led);
      chk($sformatf("tick@%0d", tbl[i].cyc), {7'b0, TICK}, {7'b0, tbl[i].tick});
      SW_EN   = tbl[i].en;
      SW_MODE = tbl[i].mode;
    end

    // ping-pong running, then an asynchronous reset between clock edges
    run_to(448);
    chk("pp_before_rst", LED, 8'h04);
    run_to(452);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_led", LED, 8'h00);
    chk("async_rst_tick", {7'b0, TICK}, 8'h00);
    adv();
    adv();
    chk("rst_hold_led", LED, 8'h00);
    RST = 1'b0;
    ecount = 0;
    run_to(7);
    chk("rerun_e7", LED, 8'h00);
    run_to(8);
    chk("rerun_e8", LED, 8'h01);
    run_to(18);
    chk("rerun_e18", LED, 8'h02);
    run_to(28);
    chk("rerun_e28", LED, 8'h04);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
